score_tracker: RTL and testbench

- Sits directly downstream of the per-lane arrow dropper instances.
- Consumes each dropper's score flag and finish indication, and judges every lane exactly once per round as a hit or a miss.
- Accumulates score with a combo multiplier and tracks combo, max combo, hit count and miss count.
- Drives the game-level round state (idle / playing / over) to the HUD and VGA overlay logic.

---
 rtl/rhythm_pkg.sv | 19 +
 rtl/lane_popcount.sv | 17 +
 rtl/score_tracker.sv | 146 ++++++++++++++
 tb/tb_score_tracker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game datapath: round state, key codes and
// the saturating byte adder used by the score tracker.
package rhythm_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

  localparam logic [7:0] KEY_START   = 8'h2c;
  localparam logic [7:0] KEY_RESTART = 8'h01;
  localparam logic [7:0] KEY_LANE_A  = 8'h04;

  localparam int unsigned MULT_MAX = 4;

  function automatic logic [7:0] sat8_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

endpackage

// File: rtl/lane_popcount.sv
// Population count over an N-bit lane mask.
module lane_popcount #(
  parameter int unsigned N = 24,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Judges each dropper lane once per round as hit or miss, accumulates score with a
// combo multiplier and drives the idle/playing/over round state.
module score_tracker
  import rhythm_pkg::*;
#(
  parameter int unsigned N_LANES     = 24,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned PTS_PER_HIT = 10,
  parameter int unsigned COMBO_STEP  = 10
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [N_LANES-1:0] hit_flag,
  input  logic [N_LANES-1:0] done_flag,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [7:0]         hit_count,
  output logic [7:0]         miss_count,
  output logic               playing,
  output logic               game_over
);

  localparam int unsigned CW = $clog2(N_LANES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         combo_q, combo_d;
  logic [7:0]         max_combo_q, max_combo_d;
  logic [7:0]         hit_count_q, hit_count_d;
  logic [7:0]         miss_count_q, miss_count_d;
  logic [N_LANES-1:0] done_prev_q;
  logic [N_LANES-1:0] done_seen_q, done_seen_d;

  logic [N_LANES-1:0] new_lanes, hits, misses, seen_all;
  logic [CW-1:0]      nh, nm;
  logic [31:0]        tier;
  logic [2:0]         mult;
  logic [31:0]        pts;
  logic [32:0]        score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [7:0]         combo_plus;

  // A lane is judged only on a fresh rising done edge it has not been judged for yet.
  assign new_lanes = done_flag & ~done_prev_q & ~done_seen_q;
  assign hits      = new_lanes & hit_flag;
  assign misses    = new_lanes & ~hit_flag;
  assign seen_all  = done_seen_q | new_lanes;

  lane_popcount #(.N(N_LANES)) u_hit_pop (
    .bits  (hits),
    .count (nh)
  );

  lane_popcount #(.N(N_LANES)) u_miss_pop (
    .bits  (misses),
    .count (nm)
  );

  always_comb begin
    tier = 32'(combo_q) / COMBO_STEP;
    if (tier >= MULT_MAX - 1) begin
      mult = 3'(MULT_MAX);
    end else begin
      mult = 3'(tier + 1);
    end
    pts        = 32'(nh) * PTS_PER_HIT * 32'(mult);
    score_sum  = {1'b0, 32'(score_q)} + {1'b0, pts};
    score_sat  = (score_sum > 33'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    combo_plus = sat8_add(combo_q, 8'(nh));
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    combo_d      = combo_q;
    max_combo_d  = max_combo_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    done_seen_d  = done_seen_q;
    case (state_q)
      IDLE: begin
        if (keycode == KEY_START) begin
          state_d      = PLAY;
          score_d      = '0;
          combo_d      = '0;
          max_combo_d  = '0;
          hit_count_d  = '0;
          miss_count_d = '0;
          done_seen_d  = '0;
        end
      end
      PLAY: begin
        score_d      = score_sat;
        hit_count_d  = sat8_add(hit_count_q, 8'(nh));
        miss_count_d = sat8_add(miss_count_q, 8'(nm));
        combo_d      = (nm != '0) ? 8'd0 : combo_plus;
        max_combo_d  = (combo_plus > max_combo_q) ? combo_plus : max_combo_q;
        done_seen_d  = seen_all;
        if (&seen_all) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Counters hold so the HUD keeps showing the final result.
        if (keycode == KEY_RESTART) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      score_q      <= '0;
      combo_q      <= '0;
      max_combo_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      done_prev_q  <= '0;
      done_seen_q  <= '0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      max_combo_q  <= max_combo_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      done_prev_q  <= done_flag;
      done_seen_q  <= done_seen_d;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign max_combo  = max_combo_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign playing    = (state_q == PLAY);
  assign game_over  = (state_q == DONE);

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: a table-driven round plus hand sequences for the
// multiplier step, mid-round reset, mixed hit/miss edge and repeat-edge suppression.
module tb_score_tracker;

  logic        frame_clk;
  logic        Reset;
  logic [7:0]  keycode;
  logic [23:0] hit_flag;
  logic [23:0] done_flag;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [7:0]  hit_count;
  logic [7:0]  miss_count;
  logic        playing;
  logic        game_over;

  int n_cmp = 0;
  int n_err = 0;

  score_tracker #(
    .N_LANES     (24),
    .SCORE_W     (16),
    .PTS_PER_HIT (10),
    .COMBO_STEP  (10)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .hit_flag   (hit_flag),
    .done_flag  (done_flag),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .playing    (playing),
    .game_over  (game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [7:0]  key;
    logic [23:0] done;
    logic [23:0] hit;
    int          sc;
    int          cb;
    int          mx;
    int          hc;
    int          mc;
    int          pl;
    int          ov;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int sc, input int cb, input int mx,
                         input int hc, input int mc, input int pl, input int ov);
    chk({tag, ".score"}, int'(score), sc);
    chk({tag, ".combo"}, int'(combo), cb);
    chk({tag, ".max_combo"}, int'(max_combo), mx);
    chk({tag, ".hit_count"}, int'(hit_count), hc);
    chk({tag, ".miss_count"}, int'(miss_count), mc);
    chk({tag, ".playing"}, int'(playing), pl);
    chk({tag, ".game_over"}, int'(game_over), ov);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    logic [23:0] d;
    logic [23:0] h;

    // One full round; lanes 0..23 judged across t1..t8.
    vecs[0]  = '{8'h2c, 24'h000000, 24'h000000,   0,  0,  0,  0, 0, 1, 0};
    vecs[1]  = '{8'h00, 24'h000001, 24'h000001,  10,  1,  1,  1, 0, 1, 0};
    vecs[2]  = '{8'h00, 24'h000001, 24'h000000,  10,  1,  1,  1, 0, 1, 0};
    vecs[3]  = '{8'h00, 24'h000000, 24'h000000,  10,  1,  1,  1, 0, 1, 0};
    vecs[4]  = '{8'h00, 24'h000001, 24'h000001,  10,  1,  1,  1, 0, 1, 0};
    vecs[5]  = '{8'h00, 24'h000002, 24'h000000,  10,  0,  1,  1, 1, 1, 0};
    vecs[6]  = '{8'h00, 24'h00003c, 24'h00001c,  40,  0,  3,  4, 2, 1, 0};
    vecs[7]  = '{8'h00, 24'h0001c0, 24'h0001c0,  70,  3,  3,  7, 2, 1, 0};
    vecs[8]  = '{8'h00, 24'hfffe00, 24'hfffe00, 220, 18, 18, 22, 2, 0, 1};
    vecs[9]  = '{8'h2c, 24'h000000, 24'h000000, 220, 18, 18, 22, 2, 0, 1};
    vecs[10] = '{8'h01, 24'h000000, 24'h000000, 220, 18, 18, 22, 2, 0, 0};
    vecs[11] = '{8'h2c, 24'h000000, 24'h000000,   0,  0,  0,  0, 0, 1, 0};

    Reset     = 1'b0;
    keycode   = 8'h00;
    hit_flag  = '0;
    done_flag = '0;
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    #10;
    Reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      keycode   = vecs[i].key;
      done_flag = vecs[i].done;
      hit_flag  = vecs[i].hit;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].sc, vecs[i].cb, vecs[i].mx, vecs[i].hc,
              vecs[i].mc, vecs[i].pl, vecs[i].ov);
    end

    // Twelve sequential hits: ten at x1, then two at x2.
    keycode = 8'h00;
    d = '0;
    for (int i = 0; i < 12; i++) begin
      d[i]      = 1'b1;
      done_flag = d;
      hit_flag  = d;
      tick();
      if (i == 9) chk("seq12.score_at_10", int'(score), 100);
      if (i == 10) chk("seq12.score_at_11", int'(score), 120);
    end
    chk_all("seq12", 140, 12, 12, 12, 0, 1, 0);

    // Fresh round reaching score 40, then asynchronous reset mid-cycle.
    done_flag = '0;
    hit_flag  = '0;
    #2 Reset = 1'b0;
    #2 Reset = 1'b1;
    keycode = 8'h2c;
    tick();
    keycode = 8'h00;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[i]      = 1'b1;
      done_flag = d;
      hit_flag  = d;
      tick();
    end
    chk("rst.pre_score", int'(score), 40);
    #3 Reset = 1'b0;
    #1;
    chk("rst.score", int'(score), 0);
    chk("rst.combo", int'(combo), 0);
    chk("rst.playing", int'(playing), 0);
    #2 Reset = 1'b1;
    done_flag = '0;
    hit_flag  = '0;
    tick();
    chk_all("rst.idle", 0, 0, 0, 0, 0, 0, 0);

    // Lane 23 already high at round start: never judged.
    done_flag = 24'h800000;
    hit_flag  = 24'h800000;
    keycode   = 8'h2c;
    tick();
    keycode = 8'h00;
    d = 24'h800000;
    for (int i = 5; i < 10; i++) begin
      d[i]      = 1'b1;
      done_flag = d;
      hit_flag  = d;
      tick();
    end
    chk_all("combo5", 50, 5, 5, 5, 0, 1, 0);

    // Lanes 1-3 hit and lane 4 misses on one edge.
    d         = d | 24'h00001e;
    h         = d & ~24'h000010;
    done_flag = d;
    hit_flag  = h;
    tick();
    chk_all("mixed", 80, 0, 8, 8, 1, 1, 0);

    // Lane 10 held for 50 frames, dropped, raised again: judged once.
    d[10]     = 1'b1;
    h[10]     = 1'b1;
    done_flag = d;
    hit_flag  = h;
    tick();
    chk_all("hold.first", 90, 1, 8, 9, 1, 1, 0);
    for (int i = 0; i < 49; i++) tick();
    chk("hold.held_hits", int'(hit_count), 9);
    d[10]     = 1'b0;
    done_flag = d;
    tick();
    d[10]     = 1'b1;
    done_flag = d;
    tick();
    tick();
    chk_all("hold.rerise", 90, 1, 8, 9, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
